mem_arbiter: RTL and testbench

// - Shares the single RAM port between the dcache and the icache. Serialises word-level requests and forwards

---
 rtl/cpu_types_pkg.sv | 28 ++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the memory-control layer.
//   ramstate_t  : status reported by the RAM port (FREE/BUSY/ACCESS/ERROR)
//   arb_state_t : ownership state of the cache/RAM arbiter
//   STARVE_LIMIT_DEF / CNT_W_DEF : default starvation-counter sizing
// ---------------------------------------------------------------------------
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2
  } arb_state_t;

  // Blocked icache-request cycles tolerated before the icache wins arbitration.
  localparam int STARVE_LIMIT_DEF = 8;
  // Counter width; STARVE_LIMIT must fit strictly below 2**CNT_W.
  localparam int CNT_W_DEF        = 4;

endpackage

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares the single RAM port between the dcache and the icache. One word is
// moved per grant; every completed word returns the arbiter to IDLE so the
// other cache can be interleaved between the words of a burst. The dcache has
// priority, but a saturating starvation counter forces an icache grant once
// the icache has been kept waiting for STARVE_LIMIT request cycles.
//
// Ports
//   CLK, RST           clock, synchronous active-high reset
//   dREN, dWEN         dcache word read / write request
//   daddr, dstore      dcache word address / write data
//   dwait, dload       dcache handshake: dwait low for the completing cycle,
//                      dload valid in that cycle (0 otherwise)
//   iREN, iaddr        icache word read request / address
//   iwait, iload       icache handshake, same rules as the dcache side
//   ramREN, ramWEN     RAM read / write enable
//   ramaddr, ramstore  RAM address / write data (pass-through, not latched)
//   ramload            RAM read data
//   ramstate           RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
// ---------------------------------------------------------------------------
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  // dcache side
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  // icache side
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  // RAM side
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_starve_cnt;

  ramstate_t        w_ramstate;
  logic             w_d_req;
  logic             w_d_done;
  logic             w_i_done;
  logic             w_i_starved;

  assign w_ramstate  = ramstate_t'(ramstate);
  assign w_d_req     = dREN | dWEN;
  // A word completes only while its requester is still asking; a request
  // dropped in the same cycle as ACCESS is treated as an abort.
  assign w_d_done    = (r_state == DACC) && w_d_req && (w_ramstate == ACCESS);
  assign w_i_done    = (r_state == IACC) && iREN    && (w_ramstate == ACCESS);
  assign w_i_starved = (r_starve_cnt == LIMIT);

  // ---- state register ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (iREN && w_i_starved) begin
          w_state_nxt = IACC;
        end else if (w_d_req) begin
          w_state_nxt = DACC;
        end else if (iREN) begin
          w_state_nxt = IACC;
        end
      end
      // ERROR/BUSY/FREE hold the grant so the RAM retries with the same
      // enables; ACCESS or an abort hands the port back to arbitration.
      DACC: begin
        if (w_d_done || !w_d_req) begin
          w_state_nxt = IDLE;
        end
      end
      IACC: begin
        if (w_i_done || !iREN) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---- output logic ----
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    dwait    = 1'b1;
    dload    = '0;
    iwait    = 1'b1;
    iload    = '0;
    unique case (r_state)
      DACC: begin
        ramaddr  = daddr;
        ramstore = dstore;
        // Write takes precedence when both enables are raised.
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (w_d_done) begin
          dwait = 1'b0;
          dload = ramload;
        end
      end
      IACC: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
        if (w_i_done) begin
          iwait = 1'b0;
          iload = ramload;
        end
      end
      default: begin
      end
    endcase
  end

  // ---- starvation counter ----
  // Counts every cycle the icache is asking but not owning the port, so a
  // dcache word (IDLE + DACC) costs the icache two counts.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_starve_cnt <= '0;
    end else if (w_i_done) begin
      r_starve_cnt <= '0;
    end else if (iREN && (r_state != IACC) && !w_i_starved) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Scoreboard bench: each stimulus cycle the reference model predicts the
// complete output vector and pushes it on a queue; a monitor pops and compares
// on the falling edge. Directed scenarios add constant checks on top.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int LIM = 8;
  // Each dcache word keeps a waiting icache pending for two cycles.
  localparam int WPR = LIM / 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        dREN, dWEN, iREN;
  logic [31:0] daddr, dstore, iaddr, ramload;
  logic [1:0]  ramstate;
  logic        dwait, iwait, ramREN, ramWEN;
  logic [31:0] dload, iload, ramaddr, ramstore;

  always #5 CLK = ~CLK;

  mem_arbiter #(.STARVE_LIMIT(LIM), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  typedef struct packed {
    logic        dwait;
    logic        iwait;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] dload;
    logic [31:0] iload;
  } exp_t;

  exp_t exp_q[$];
  int   obs_seq[$];   // 1 = dcache word completed, 2 = icache word completed
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: who owns the RAM port (0 none, 1 dcache, 2 icache) and
  // how long the icache has been kept waiting.
  int   m_owner = 0;
  int   m_cnt   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic int count_from(input int mark, input int who);
    int c = 0;
    for (int k = mark; k < obs_seq.size(); k++) if (obs_seq[k] == who) c++;
    return c;
  endfunction

  // Predict this cycle's outputs from the current inputs, then advance the
  // model across the coming clock edge.
  task automatic step();
    exp_t e;
    bit   dreq;
    bit   done;
    int   nxt;
    e       = '0;
    e.dwait = 1'b1;
    e.iwait = 1'b1;
    dreq    = dREN | dWEN;
    done    = 1'b0;
    nxt     = m_owner;
    if (m_owner == 0) begin
      if (iREN && m_cnt == LIM) nxt = 2;
      else if (dreq)            nxt = 1;
      else if (iREN)            nxt = 2;
    end else if (m_owner == 1) begin
      e.addr  = daddr;
      e.store = dstore;
      e.wen   = dWEN;
      e.ren   = dREN && !dWEN;
      done    = dreq && ramstate == 2'd2;
      if (done) begin
        e.dwait = 1'b0;
        e.dload = ramload;
      end
      if (done || !dreq) nxt = 0;
    end else begin
      e.addr = iaddr;
      e.ren  = 1'b1;
      done   = iREN && ramstate == 2'd2;
      if (done) begin
        e.iwait = 1'b0;
        e.iload = ramload;
      end
      if (done || !iREN) nxt = 0;
    end
    exp_q.push_back(e);
    if (m_owner == 2 && done)                  m_cnt = 0;
    else if (iREN && m_owner != 2 && m_cnt < LIM) m_cnt = m_cnt + 1;
    m_owner = nxt;
    if (RST) begin
      m_owner = 0;
      m_cnt   = 0;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    exp_t a;
    forever begin
      @(negedge CLK);
      if (exp_q.size() != 0) begin
        e       = exp_q.pop_front();
        a.dwait = dwait;
        a.iwait = iwait;
        a.ren   = ramREN;
        a.wen   = ramWEN;
        a.addr  = ramaddr;
        a.store = ramstore;
        a.dload = dload;
        a.iload = iload;
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL cycle_outputs t=%0t got %h expected %h", $time, a, e);
        end
      end
      if (dwait === 1'b0) obs_seq.push_back(1);
      if (iwait === 1'b0) obs_seq.push_back(2);
    end
  endtask

  task automatic idle_inputs();
    dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0;
    ramstate = 2'd0;
  endtask

  initial begin
    int mark;
    fork
      monitor();
    join_none

    RST = 1'b1;
    idle_inputs();
    daddr = '0; dstore = '0; iaddr = '0; ramload = '0;
    @(posedge CLK);
    #1;

    // Reset held two cycles with a dcache read pending.
    dREN = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("rst_ramREN", 32'(ramREN), 32'd0);
      chk("rst_dwait",  32'(dwait),  32'd1);
      chk("rst_iwait",  32'(iwait),  32'd1);
      step();
    end
    RST = 1'b0;
    daddr = 32'h0000_0100;
    #1;
    chk("post_rst_idle_ramREN", 32'(ramREN), 32'd0);
    step();
    #1;
    chk("grant_after_rst_ramREN", 32'(ramREN), 32'd1);
    chk("grant_after_rst_addr", ramaddr, 32'h0000_0100);
    ramstate = 2'd2;
    ramload  = 32'hCAFE_0001;
    step();
    idle_inputs();
    step();

    // Lone dcache write.
    mark = obs_seq.size();
    dWEN = 1'b1; daddr = 32'h0000_3100; dstore = 32'h0000_DEAD;
    step();
    ramstate = 2'd2;
    #1;
    chk("wr_ramWEN",   32'(ramWEN), 32'd1);
    chk("wr_ramREN",   32'(ramREN), 32'd0);
    chk("wr_ramaddr",  ramaddr,     32'h0000_3100);
    chk("wr_ramstore", ramstore,    32'h0000_DEAD);
    chk("wr_dwait",    32'(dwait),  32'd0);
    step();
    idle_inputs();
    #1;
    chk("wr_dwait_after", 32'(dwait), 32'd1);
    step();
    step();
    chk("wr_dwait_low_cycles", 32'(count_from(mark, 1)), 32'd1);

    // Contention: both caches asking, RAM answers at once on every grant.
    mark = obs_seq.size();
    dREN = 1'b1; iREN = 1'b1; ramstate = 2'd2;
    daddr = 32'h0000_2000; iaddr = 32'h0000_8000;
    repeat (25) begin
      ramload = $urandom;
      step();
    end
    idle_inputs();
    step();
    step();
    chk("contention_words", 32'(obs_seq.size() - mark >= 2 * (WPR + 1)), 32'd1);
    for (int k = 0; k < 2 * (WPR + 1); k++) begin
      if (mark + k < obs_seq.size())
        chk($sformatf("contention_order_%0d", k), 32'(obs_seq[mark + k]),
            (k % (WPR + 1) == WPR) ? 32'd2 : 32'd1);
    end

    // icache access retried through three ERROR cycles.
    iREN = 1'b1; iaddr = 32'h0000_0440; ramstate = 2'd3;
    step();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("err_iwait",  32'(iwait),  32'd1);
      chk("err_ramREN", 32'(ramREN), 32'd1);
      step();
    end
    ramstate = 2'd2; ramload = 32'h0000_1234;
    #1;
    chk("err_iwait_done", 32'(iwait), 32'd0);
    chk("err_iload",      iload,      32'h0000_1234);
    chk("err_dload_zero", dload,      32'd0);
    step();
    idle_inputs();
    step();

    // Read and write raised together: the write wins.
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h0000_0A00; dstore = 32'h5555_AAAA;
    step();
    #1;
    chk("both_ramWEN", 32'(ramWEN), 32'd1);
    chk("both_ramREN", 32'(ramREN), 32'd0);
    ramstate = 2'd2;
    step();
    idle_inputs();
    step();

    // Abort: dREN dropped before the RAM answers.
    mark = obs_seq.size();
    dREN = 1'b1; daddr = 32'h0000_0B00;
    step();
    ramstate = 2'd1;
    #1;
    chk("abort_busy_dwait", 32'(dwait), 32'd1);
    step();
    dREN = 1'b0; ramstate = 2'd2;
    #1;
    chk("abort_dwait", 32'(dwait), 32'd1);
    step();
    #1;
    chk("abort_idle_ramREN", 32'(ramREN), 32'd0);
    step();
    chk("abort_no_completion", 32'(count_from(mark, 1)), 32'd0);

    // Randomized traffic with occasional reset.
    repeat (3000) begin
      RST      = ($urandom_range(0, 199) == 0);
      dREN     = ($urandom_range(0, 2) == 0);
      dWEN     = ($urandom_range(0, 3) == 0);
      iREN     = ($urandom_range(0, 1) == 0);
      daddr    = $urandom;
      dstore   = $urandom;
      iaddr    = $urandom;
      ramload  = $urandom;
      ramstate = 2'($urandom_range(0, 3));
      step();
    end
    RST = 1'b0;
    idle_inputs();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
